// File: rtl/mem_arbiter.sv
// N-client arbiter onto a single valid/ready memory bus.
// One transaction in flight; registered outputs; optional watchdog.
module mem_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_instr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]              req_ready,
    output logic [NUM_PORTS-1:0]              req_error,
    output logic [DATA_WIDTH-1:0]             req_rdata,
    output logic                              busy,
    output logic                              mem_valid,
    output logic                              mem_instr,
    input  logic                              mem_ready,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_wstrb,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_instr_q, mem_instr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]          mem_wstrb_q, mem_wstrb_d;
    logic [NUM_PORTS-1:0]   req_ready_q, req_ready_d;
    logic [NUM_PORTS-1:0]   req_error_q, req_error_d;
    logic [DATA_WIDTH-1:0]  req_rdata_q, req_rdata_d;
    logic                   busy_q, busy_d;

    logic [GW-1:0]          grant;
    logic                   found;

    // Round-robin searches upward from the port after the last winner.
    always_comb begin
        grant = last_grant_q;
        found = 1'b0;
        if (PRIORITY_MODE != 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant = GW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                int idx;
                idx = (int'(last_grant_q) + k) % NUM_PORTS;
                if (!found && req_valid[idx]) begin
                    grant = GW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_instr_d  = mem_instr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        req_ready_d  = '0;
        req_error_d  = '0;
        req_rdata_d  = req_rdata_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req_valid) begin
                    last_grant_d = grant;
                    mem_valid_d  = 1'b1;
                    mem_instr_d  = req_instr[grant];
                    mem_addr_d   = req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d  = req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                    mem_wstrb_d  = req_wstrb[int'(grant)*SW +: SW];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    req_rdata_d = mem_rdata;
                    req_ready_d = NUM_PORTS'(1) << last_grant_q;
                    mem_valid_d = 1'b0;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    req_rdata_d = '0;
                    req_ready_d = NUM_PORTS'(1) << last_grant_q;
                    req_error_d = NUM_PORTS'(1) << last_grant_q;
                    mem_valid_d = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_PORT;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            req_ready_q  <= '0;
            req_error_q  <= '0;
            req_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_instr_q  <= mem_instr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            req_ready_q  <= req_ready_d;
            req_error_q  <= req_error_d;
            req_rdata_q  <= req_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign req_ready = req_ready_q;
    assign req_error = req_error_q;
    assign req_rdata = req_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 2-port round-robin instance with
// watchdog and a 3-port fixed-priority instance.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 2 ports, round-robin, TIMEOUT=4
    logic [1:0]  req_valid_a = '0, req_instr_a = '0;
    logic [63:0] req_addr_a = '0, req_wdata_a = '0;
    logic [7:0]  req_wstrb_a = '0;
    logic [1:0]  req_ready_a, req_error_a;
    logic [31:0] req_rdata_a;
    logic        busy_a, mem_valid_a, mem_instr_a;
    logic        mem_ready_a = 1'b0;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_wstrb_a;
    logic [31:0] mem_rdata_a = '0;

    mem_arbiter #(.NUM_PORTS(2), .PRIORITY_MODE(0), .TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_instr(req_instr_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .req_wstrb(req_wstrb_a), .req_ready(req_ready_a),
        .req_error(req_error_a), .req_rdata(req_rdata_a),
        .busy(busy_a), .mem_valid(mem_valid_a), .mem_instr(mem_instr_a),
        .mem_ready(mem_ready_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a),
        .mem_rdata(mem_rdata_a)
    );

    // Instance B: 3 ports, fixed priority, no watchdog
    logic [2:0]  req_valid_b = '0;
    logic [2:0]  req_instr_b = '0;
    logic [95:0] req_addr_b = '0, req_wdata_b = '0;
    logic [11:0] req_wstrb_b = '0;
    logic [2:0]  req_ready_b, req_error_b;
    logic [31:0] req_rdata_b;
    logic        busy_b, mem_valid_b, mem_instr_b;
    logic        mem_ready_b = 1'b0;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;
    logic [31:0] mem_rdata_b = '0;

    mem_arbiter #(.NUM_PORTS(3), .PRIORITY_MODE(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_instr(req_instr_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .req_wstrb(req_wstrb_b), .req_ready(req_ready_b),
        .req_error(req_error_b), .req_rdata(req_rdata_b),
        .busy(busy_b), .mem_valid(mem_valid_b), .mem_instr(mem_instr_b),
        .mem_ready(mem_ready_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rdata(mem_rdata_b)
    );

    typedef struct {
        logic [68:0] bus;
        int          dur;
    } bus_t;
    typedef struct {
        int          port;
        bit          err;
        logic [31:0] rdata;
        int          gap;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    rsp_t rspb_q[$];

    int  mem_wait = 0;
    bit  hang = 1'b0;

    function automatic logic [31:0] rd_for(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
    endfunction

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Memory model A: fixed wait states, or never answers when hung
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            mem_rdata_a = hang ? 32'hBAD0_BAD0 : rd_for(mem_addr_a);
            if (reset || !mem_valid_a) begin
                mem_ready_a = 1'b0;
                wcnt = 0;
            end else if (!hang && wcnt == mem_wait) begin
                mem_ready_a = 1'b1;
            end else begin
                mem_ready_a = 1'b0;
                wcnt++;
            end
        end
    end

    // Memory model B: zero-wait
    initial forever begin
        @(negedge clk);
        mem_ready_b = mem_valid_b && !reset;
        mem_rdata_b = ~mem_addr_b;
    end

    // Bus monitor A: content held for the whole request, duration checked
    initial begin
        bit   prev_v;
        int   dur;
        bus_t cur;
        prev_v = 1'b0;
        dur = 0;
        cur.bus = '0;
        cur.dur = 0;
        forever begin
            @(negedge clk);
            if (mem_valid_a && !prev_v) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected act=addr %h exp=none", mem_addr_a);
                end else begin
                    cur = bus_q.pop_front();
                end
                dur = 0;
            end
            if (mem_valid_a) begin
                dur++;
                chk("bus_fields", {mem_instr_a, mem_wstrb_a, mem_addr_a, mem_wdata_a},
                    cur.bus);
            end
            if (!mem_valid_a && prev_v)
                chk("bus_duration", dur, cur.dur);
            prev_v = mem_valid_a;
        end
    end

    // Response monitor A
    initial begin
        int   last;
        rsp_t e;
        last = 0;
        forever begin
            @(negedge clk);
            if (|req_ready_a) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected act=%b exp=none", req_ready_a);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_port", req_ready_a, 2'b01 << e.port);
                    chk("rsp_error", req_error_a, e.err ? (2'b01 << e.port) : 2'b00);
                    chk("rsp_rdata", req_rdata_a, e.rdata);
                    if (e.gap != 0)
                        chk("rsp_gap", cyc - last, e.gap);
                end
                last = cyc;
            end else if (|req_error_a) begin
                chk("err_without_ready", req_error_a, 2'b00);
            end
        end
    end

    // Response monitor B
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (|req_ready_b) begin
                if (rspb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rspb_unexpected act=%b exp=none", req_ready_b);
                end else begin
                    e = rspb_q.pop_front();
                    chk("rspb_port", req_ready_b, 3'b001 << e.port);
                    chk("rspb_error", req_error_b, 3'b000);
                    chk("rspb_rdata", req_rdata_b, e.rdata);
                end
            end
        end
    end

    task automatic set_a(input int p, input bit instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        req_instr_a[p]          = instr;
        req_addr_a[p*32 +: 32]  = addr;
        req_wdata_a[p*32 +: 32] = wdata;
        req_wstrb_a[p*4 +: 4]   = wstrb;
    endtask

    task automatic exp_a(input int p, input bit instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int dur, input bit err, input int gap, input bit rsp);
        bus_t b;
        rsp_t r;
        b.bus = {instr, wstrb, addr, wdata};
        b.dur = dur;
        bus_q.push_back(b);
        if (rsp) begin
            r.port  = p;
            r.err   = err;
            r.rdata = err ? 32'h0 : rd_for(addr);
            r.gap   = gap;
            rsp_q.push_back(r);
        end
    endtask

    task automatic exp_b(input int p, input logic [31:0] addr);
        rsp_t r;
        r.port  = p;
        r.err   = 1'b0;
        r.rdata = ~addr;
        r.gap   = 0;
        rspb_q.push_back(r);
    endtask

    task automatic wait_rdy(input bit use_b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (use_b ? (|req_ready_b) : (|req_ready_a)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_ready act=timeout exp=pulse");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", mem_valid_a, 0);
        chk("rst_mem_instr", mem_instr_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        chk("rst_mem_wstrb", mem_wstrb_a, 0);
        chk("rst_req_ready", req_ready_a, 0);
        chk("rst_req_error", req_error_a, 0);
        chk("rst_req_rdata", req_rdata_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_b_valid", {busy_b, mem_valid_b}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single fetch read, 2 wait states
        mem_wait = 2;
        set_a(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        exp_a(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 3, 1'b0, 0, 1'b1);
        req_valid_a = 2'b01;
        @(negedge clk);
        chk("latency_valid", mem_valid_a, 1);
        chk("issue_busy", busy_a, 1);
        wait_rdy(1'b0);
        req_valid_a = 2'b00;
        @(negedge clk);
        chk("ready_one_cycle", req_ready_a, 0);
        chk("idle_busy", busy_a, 0);

        // Write from port 1
        mem_wait = 1;
        set_a(1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b0011);
        exp_a(1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b0011, 2, 1'b0, 0, 1'b1);
        req_valid_a = 2'b10;
        wait_rdy(1'b0);
        req_valid_a = 2'b00;
        repeat (2) @(negedge clk);

        // Contention, zero-wait: grants alternate every 3 cycles
        mem_wait = 0;
        set_a(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        set_a(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        exp_a(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, 1'b0, 0, 1'b1);
        exp_a(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 1, 1'b0, 3, 1'b1);
        exp_a(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, 1'b0, 3, 1'b1);
        exp_a(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 1, 1'b0, 3, 1'b1);
        req_valid_a = 2'b11;
        repeat (4) wait_rdy(1'b0);
        req_valid_a = 2'b00;
        repeat (2) @(negedge clk);

        // Watchdog: no mem_ready, then a normal request
        hang = 1'b1;
        set_a(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        exp_a(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 4, 1'b1, 0, 1'b1);
        req_valid_a = 2'b01;
        wait_rdy(1'b0);
        req_valid_a = 2'b00;
        hang = 1'b0;
        @(negedge clk);
        set_a(0, 1'b0, 32'h0000_3004, 32'h0, 4'h0);
        exp_a(0, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 1, 1'b0, 0, 1'b1);
        req_valid_a = 2'b01;
        wait_rdy(1'b0);
        req_valid_a = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during wait states: aborted, then port 0 wins again
        hang = 1'b1;
        set_a(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        exp_a(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 2, 1'b0, 0, 1'b0);
        req_valid_a = 2'b01;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_valid_a = 2'b00;
        @(negedge clk);
        chk("rst_mid_valid", mem_valid_a, 0);
        chk("rst_mid_ready", req_ready_a, 0);
        reset = 1'b0;
        hang = 1'b0;
        repeat (3) @(negedge clk);
        set_a(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
        set_a(1, 1'b0, 32'h0000_5004, 32'h0, 4'h0);
        exp_a(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 1, 1'b0, 0, 1'b1);
        exp_a(1, 1'b0, 32'h0000_5004, 32'h0, 4'h0, 1, 1'b0, 3, 1'b1);
        req_valid_a = 2'b11;
        repeat (2) wait_rdy(1'b0);
        req_valid_a = 2'b00;
        repeat (2) @(negedge clk);

        // Fixed priority: port 1 beats port 2 until it lets go
        req_addr_b[32 +: 32] = 32'h0000_6004;
        req_addr_b[64 +: 32] = 32'h0000_6008;
        exp_b(1, 32'h0000_6004);
        exp_b(1, 32'h0000_6004);
        exp_b(1, 32'h0000_6004);
        exp_b(2, 32'h0000_6008);
        req_valid_b = 3'b110;
        repeat (3) wait_rdy(1'b1);
        req_valid_b = 3'b100;
        wait_rdy(1'b1);
        req_valid_b = 3'b000;
        repeat (3) @(negedge clk);

        chk("bus_queue_empty", bus_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("rspb_queue_empty", rspb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
